// File: rtl/bp_update_scheduler.sv
// Branch-predictor update scheduler: queues resolved branches and writes
// them into the predictor, deferring when fetch reads the same set.
module bp_update_scheduler #(
   parameter int DEPTH     = 4,
   parameter int MAX_DEFER = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     br_valid,
   input  logic [31:0]              br_pc,
   input  logic                     br_taken,
   output logic                     br_ready,
   input  logic                     fetch_valid,
   input  logic [31:0]              pc_pre,
   input  logic                     flush,
   output logic                     update_en,
   output logic [31:0]              pc_update,
   output logic                     real_br_taken,
   output logic [$clog2(DEPTH):0]   q_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = $clog2(MAX_DEFER + 1);
   localparam logic [DW-1:0] MAXD = DW'(MAX_DEFER);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state;
   logic [31:0]      q_pc [DEPTH];
   logic             q_tk [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [DW-1:0]    defer_cnt;

   logic [31:0]      head_pc;
   logic             head_tk;
   logic             not_empty;
   logic             conflict;
   logic             defer;
   logic             issue;
   logic             push;
   logic             unused_pc_bits;

   assign unused_pc_bits = &{1'b0, pc_pre[31:6], pc_pre[1:0]};

   assign head_pc   = q_pc[rd_ptr];
   assign head_tk   = q_tk[rd_ptr];
   assign not_empty = (q_count != '0);
   assign br_ready  = (q_count < CW'(DEPTH));

   // Same predictor set as the fetch lookup: back off, but only so long
   assign conflict = fetch_valid && (pc_pre[5:2] == head_pc[5:2]) && not_empty;
   assign defer    = !flush && conflict && (defer_cnt < MAXD);
   assign issue    = !flush && not_empty && !defer;
   assign push     = br_valid && br_ready && !flush;

   assign update_en = (state == ISSUE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         q_count       <= '0;
         defer_cnt     <= '0;
         pc_update     <= '0;
         real_br_taken <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            q_pc[i] <= '0;
            q_tk[i] <= 1'b0;
         end
      end else begin
         if (push) begin
            q_pc[wr_ptr] <= br_pc;
            q_tk[wr_ptr] <= br_taken;
            wr_ptr       <= wr_ptr + AW'(1);
         end

         if (issue) begin
            rd_ptr        <= rd_ptr + AW'(1);
            pc_update     <= head_pc;
            real_br_taken <= head_tk;
            defer_cnt     <= '0;
         end else if (defer) begin
            defer_cnt     <= defer_cnt + DW'(1);
         end

         unique case ({push, issue})
            2'b10:   q_count <= q_count + CW'(1);
            2'b01:   q_count <= q_count - CW'(1);
            default: q_count <= q_count;
         endcase

         unique case (1'b1)
            flush:   state <= IDLE;
            issue:   state <= ISSUE;
            defer:   state <= HOLD;
            default: state <= IDLE;
         endcase

         if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            q_count   <= '0;
            defer_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Bench for bp_update_scheduler: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_bp_update_scheduler;

   localparam int DEPTH = 4;
   localparam int MAXD  = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        br_valid = 1'b0;
   logic [31:0] br_pc = '0;
   logic        br_taken = 1'b0;
   logic        fetch_valid = 1'b0;
   logic [31:0] pc_pre = '0;
   logic        flush = 1'b0;
   logic        br_ready;
   logic        update_en;
   logic [31:0] pc_update;
   logic        real_br_taken;
   logic [2:0]  q_count;

   int n_tests = 0;
   int n_fail  = 0;

   bp_update_scheduler #(.DEPTH(DEPTH), .MAX_DEFER(MAXD)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .br_valid      (br_valid),
      .br_pc         (br_pc),
      .br_taken      (br_taken),
      .br_ready      (br_ready),
      .fetch_valid   (fetch_valid),
      .pc_pre        (pc_pre),
      .flush         (flush),
      .update_en     (update_en),
      .pc_update     (pc_update),
      .real_br_taken (real_br_taken),
      .q_count       (q_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        tk;
   } rec_t;

   rec_t        mq[$];
   int          m_defer;
   logic        m_upd;
   logic [31:0] m_pc;
   logic        m_tk;

   function automatic void model_reset();
      mq.delete();
      m_defer = 0;
      m_upd   = 1'b0;
      m_pc    = '0;
      m_tk    = 1'b0;
   endfunction

   // One clock of the scheduling rules, applied to the current inputs
   function automatic void model_step();
      bit   iss;
      bit   acc;
      rec_t h;
      iss = 1'b0;
      if (flush) begin
         mq.delete();
         m_defer = 0;
         m_upd   = 1'b0;
         return;
      end
      acc = br_valid && (mq.size() < DEPTH);
      if (mq.size() > 0) begin
         if (fetch_valid && pc_pre[5:2] == mq[0].pc[5:2] && m_defer < MAXD)
            m_defer++;
         else
            iss = 1'b1;
      end
      m_upd = iss;
      if (iss) begin
         h       = mq.pop_front();
         m_pc    = h.pc;
         m_tk    = h.tk;
         m_defer = 0;
      end
      if (acc) mq.push_back('{br_pc, br_taken});
   endfunction

   task automatic step(input bit v, input logic [31:0] pc, input bit tk,
                       input bit fv, input logic [31:0] pp, input bit fl);
      br_valid    = v;
      br_pc       = pc;
      br_taken    = tk;
      fetch_valid = fv;
      pc_pre      = pp;
      flush       = fl;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step(0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      model_reset();
      #2;
      n_tests++;
      if (q_count !== 3'd0) begin
         n_fail++; $display("FAIL rst_q_count got=%0d exp=0", q_count);
      end
      n_tests++;
      if (update_en !== 1'b0) begin
         n_fail++; $display("FAIL rst_update_en got=%b exp=0", update_en);
      end
      n_tests++;
      if (pc_update !== 32'h0 || real_br_taken !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_outputs got=%h/%b exp=0/0", pc_update, real_br_taken);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      n_tests++;
      if (br_ready !== 1'b1) begin
         n_fail++; $display("FAIL rst_br_ready got=%b exp=1", br_ready);
      end
   endtask

   task automatic test_single();
      do_reset();
      step(1, 32'h10, 1, 0, 0, 0);
      n_tests++;
      if (q_count !== 3'd1 || update_en !== 1'b0) begin
         n_fail++;
         $display("FAIL single_n1 got q=%0d en=%b exp q=1 en=0", q_count, update_en);
      end
      step(0, 0, 0, 0, 0, 0);
      n_tests++;
      if (update_en !== 1'b1 || pc_update !== 32'h10 || real_br_taken !== 1'b1) begin
         n_fail++;
         $display("FAIL single_n2 got en=%b pc=%h tk=%b exp 1/00000010/1",
                  update_en, pc_update, real_br_taken);
      end
      step(0, 0, 0, 0, 0, 0);
      n_tests++;
      if (update_en !== 1'b0 || pc_update !== 32'h10 || real_br_taken !== 1'b1) begin
         n_fail++;
         $display("FAIL single_hold got en=%b pc=%h tk=%b exp 0/00000010/1",
                  update_en, pc_update, real_br_taken);
      end
   endtask

   task automatic test_full();
      logic [31:0] got[$];
      int          pcnt;
      bit          saw_full;
      bit          acc;
      do_reset();
      pcnt     = 0;
      saw_full = 0;
      for (int c = 0; c < 24; c++) begin
         acc = (c < 16) && (mq.size() < DEPTH);
         if (c < 16)
            step(1, 32'h100 + 32'(pcnt) * 32'h40, pcnt[0], 1, 32'h200, 0);
         else
            step(0, 0, 0, 0, 0, 0);
         if (acc) pcnt++;
         if (mq.size() == DEPTH) saw_full = 1;
         if (update_en === 1'b1) got.push_back(pc_update);
         n_tests++;
         if (q_count !== 3'(mq.size()) || br_ready !== (mq.size() < DEPTH) ||
             update_en !== m_upd) begin
            n_fail++;
            $display("FAIL full_cyc%0d got q=%0d rdy=%b en=%b exp q=%0d rdy=%b en=%b",
                     c, q_count, br_ready, update_en, mq.size(),
                     mq.size() < DEPTH, m_upd);
         end
      end
      n_tests++;
      if (!saw_full) begin
         n_fail++; $display("FAIL full_reached got=0 exp=1");
      end
      n_tests++;
      if (got.size() != pcnt) begin
         n_fail++; $display("FAIL full_count got=%0d exp=%0d", got.size(), pcnt);
      end
      for (int i = 0; i < got.size(); i++) begin
         n_tests++;
         if (got[i] !== 32'h100 + 32'(i) * 32'h40) begin
            n_fail++;
            $display("FAIL full_order%0d got=%h exp=%h", i, got[i],
                     32'h100 + 32'(i) * 32'h40);
         end
      end
   endtask

   task automatic test_defer();
      do_reset();
      step(1, 32'h24, 1, 0, 0, 0);
      for (int k = 1; k <= 3; k++) begin
         step(0, 0, 0, 1, 32'h124, 0);
         n_tests++;
         if (update_en !== (k == 3) || q_count !== ((k < 3) ? 3'd1 : 3'd0)) begin
            n_fail++;
            $display("FAIL defer_k%0d got en=%b q=%0d exp en=%b", k,
                     update_en, q_count, k == 3);
         end
      end
      n_tests++;
      if (pc_update !== 32'h24) begin
         n_fail++; $display("FAIL defer_pc got=%h exp=00000024", pc_update);
      end
   endtask

   task automatic test_no_defer();
      do_reset();
      step(1, 32'h24, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'h28, 0);
      n_tests++;
      if (update_en !== 1'b1 || pc_update !== 32'h24 || real_br_taken !== 1'b0) begin
         n_fail++;
         $display("FAIL nodefer got en=%b pc=%h tk=%b exp 1/00000024/0",
                  update_en, pc_update, real_br_taken);
      end
   endtask

   task automatic fill_three(input logic [31:0] base);
      for (int i = 0; i < 3; i++)
         step(1, base + 32'(i) * 32'h40, 1, 1, 32'h0, 0);
   endtask

   task automatic test_flush();
      do_reset();
      fill_three(32'h40);
      n_tests++;
      if (q_count !== 3'd3 || update_en !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_pre got q=%0d en=%b exp q=3 en=0", q_count, update_en);
      end
      step(1, 32'h300, 1, 0, 0, 1);
      n_tests++;
      if (q_count !== 3'd0 || update_en !== 1'b0 || br_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_now got q=%0d en=%b rdy=%b exp 0/0/1",
                  q_count, update_en, br_ready);
      end
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 0, 0, 0, 0);
         n_tests++;
         if (update_en !== 1'b0 || q_count !== 3'd0) begin
            n_fail++;
            $display("FAIL flush_after%0d got en=%b q=%0d exp 0/0", k,
                     update_en, q_count);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      step(1, 32'h3c, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      fill_three(32'h80);
      n_tests++;
      if (q_count !== 3'd3 || pc_update !== 32'h3c) begin
         n_fail++;
         $display("FAIL rmid_pre got q=%0d pc=%h exp 3/0000003c", q_count, pc_update);
      end
      rst_n = 1'b0;
      model_reset();
      #2;
      n_tests++;
      if (q_count !== 3'd0 || update_en !== 1'b0 || pc_update !== 32'h0 ||
          real_br_taken !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_async got q=%0d en=%b pc=%h tk=%b exp all 0",
                  q_count, update_en, pc_update, real_br_taken);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 0, 0, 0, 0);
         n_tests++;
         if (update_en !== 1'b0 || q_count !== 3'd0) begin
            n_fail++;
            $display("FAIL rmid_after%0d got en=%b q=%0d exp 0/0", k,
                     update_en, q_count);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] pc;
      logic [31:0] pp;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         pc      = $urandom;
         pc[5:2] = 4'($urandom_range(0, 3));
         pp      = $urandom;
         pp[5:2] = 4'($urandom_range(0, 3));
         step($urandom_range(0, 3) != 0, pc, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), pp, $urandom_range(0, 39) == 0);
         n_tests++;
         if (q_count !== 3'(mq.size()) || br_ready !== (mq.size() < DEPTH) ||
             update_en !== m_upd || pc_update !== m_pc ||
             real_br_taken !== m_tk) begin
            n_fail++;
            $display("FAIL rand_cyc%0d got q=%0d rdy=%b en=%b pc=%h tk=%b exp q=%0d rdy=%b en=%b pc=%h tk=%b",
                     c, q_count, br_ready, update_en, pc_update, real_br_taken,
                     mq.size(), mq.size() < DEPTH, m_upd, m_pc, m_tk);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_full();
      test_defer();
      test_no_defer();
      test_flush();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
